// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC over a synchronous-read memory, small FIFO to decode.
// Optional simulation trace of pushes, redirects and halts when FETCH_TRACE_EN is defined.
module fetch_sequencer #(
  parameter int                ADDR_W      = 10,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                FIFO_DEPTH  = 2,
  parameter logic [5:0]        HALT_OPCODE = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = FIFO_DEPTH[CNT_W:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              pc_end;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              run, start_go, flush, pop, push, halt_hit, last_hit;
  logic [CNT_W:0]    occupancy;

  assign run         = (state == S_RUN);
  assign start_go    = start && (state == S_IDLE || state == S_DONE);
  assign flush       = start_go || (run && redirect);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  // A redirect kills the response arriving this cycle; DRAIN kills the one issued alongside the halt.
  assign push        = run && inflight && !redirect;
  assign halt_hit    = push && (mem_rdata[DATA_W-1 -: 6] == HALT_OPCODE);
  assign last_hit    = push && (inflight_pc == '1);

  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign mem_en    = run && !redirect && !pc_end && (occupancy < DEPTH_L);
  assign mem_addr  = mem_en ? pc : '0;

  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign instr    = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr] : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_next = S_RUN;
      S_RUN:          if (halt_hit || last_hit) state_next = S_DRAIN;
      S_DRAIN:        if ((count - CNT_W'(pop)) == '0) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      pc_end      <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_next;
      inflight <= mem_en;
      if (mem_en) inflight_pc <= pc;
      if (start_go) begin
        pc     <= RESET_PC;
        pc_end <= 1'b0;
      end else if (run && redirect) begin
        pc     <= redirect_pc;
        pc_end <= 1'b0;
      end else if (mem_en) begin
        // The top address is the last fetch; the PC is not allowed to wrap into a new issue.
        if (pc == '1) pc_end <= 1'b1;
        else          pc <= pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (push)            $display("fetch pc=%h instr=%h", inflight_pc, mem_rdata);
      if (run && redirect) $display("fetch redirect pc=%h", redirect_pc);
      if (halt_hit)        $display("fetch halt pc=%h", inflight_pc);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based behavioural model of the fetch stream.
module tb_fetch_sequencer;

  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 2;
  localparam logic [9:0]  MAXA   = 10'h3FF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(10'h000), .FIFO_DEPTH(DEPTH), .HALT_OPCODE(6'h3F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory with one-cycle read latency.
  logic [DATA_W-1:0] mem [0:1023];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: buffered words, one pending read, next fetch address, phase flags.
  typedef struct { logic [9:0] pc; logic [31:0] word; } entry_t;
  entry_t     q[$];
  bit         m_fetch, m_drain, m_fin, m_end, m_pend;
  logic [9:0] m_next, m_pend_pc;
  logic [9:0] last_pop_pc;

  function automatic bit is_halt(input logic [31:0] w);
    return w[31:26] == 6'h3F;
  endfunction

  function automatic bit exp_issue();
    int pops;
    pops = (q.size() > 0 && instr_ready) ? 1 : 0;
    return m_fetch && !redirect && !m_end && (q.size() + int'(m_pend) - pops) < DEPTH;
  endfunction

  initial begin
    q.delete();
    {m_fetch, m_drain, m_fin, m_end, m_pend} = '0;
    m_next = '0; m_pend_pc = '0; last_pop_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        {m_fetch, m_drain, m_fin, m_end, m_pend} = '0;
        m_next = '0;
      end
      begin
        bit pop, iss, e_valid;
        pop     = (q.size() > 0) && instr_ready;
        iss     = exp_issue();
        e_valid = q.size() > 0;
        check("busy",        busy,        m_fetch || m_drain);
        check("done",        done,        m_fin);
        check("mem_en",      mem_en,      iss);
        check("mem_addr",    mem_addr,    iss ? m_next : 10'h0);
        check("instr_valid", instr_valid, e_valid);
        check("instr",       instr,       e_valid ? q[0].word : 32'h0);
        check("instr_pc",    instr_pc,    e_valid ? q[0].pc : 10'h0);
        if (rst_n) begin
          if (pop) last_pop_pc = q[0].pc;
          if (m_fetch) begin
            if (pop) void'(q.pop_front());
            if (redirect) begin
              q.delete();
              m_pend = 0; m_end = 0; m_next = redirect_pc;
            end else begin
              if (m_pend) begin
                q.push_back('{m_pend_pc, mem[m_pend_pc]});
                if (is_halt(mem[m_pend_pc]) || m_pend_pc == MAXA) begin
                  m_fetch = 0; m_drain = 1;
                end
              end
              m_pend = iss;
              if (iss) begin
                m_pend_pc = m_next;
                if (m_next == MAXA) m_end = 1;
                else                m_next = m_next + 1'b1;
              end
            end
          end else if (m_drain) begin
            if (pop) void'(q.pop_front());
            m_pend = 0;
            if (q.size() == 0) begin m_drain = 0; m_fin = 1; end
          end else if (start) begin
            q.delete();
            m_fetch = 1; m_fin = 0; m_end = 0; m_pend = 0; m_next = 10'h000;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int halt_pct);
    for (int a = 0; a < 1024; a++) begin
      logic [31:0] w;
      w = $urandom;
      if (int'($urandom_range(99)) < halt_pct) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F)              w[31:26] = 6'h00;
      mem[a] = w;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check({name, " reached done"}, done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    fill(0);
    step(); step();
    check("reset busy",  busy, 1'b0);
    check("reset valid", instr_valid, 1'b0);
    check("reset mem_en", mem_en, 1'b0);
    rst_n = 1'b1;
    step();

    // Streaming: four words then a halt; address 5 must never reach decode.
    mem[0] = 32'h0000_0001; mem[1] = 32'h0000_0002; mem[2] = 32'h0000_0003;
    mem[3] = 32'h0000_0004; mem[4] = 32'hFC00_0000; mem[5] = 32'h0000_0055;
    instr_ready = 1'b1;
    pulse_start();                                       // cycle 1
    check("stream first mem_en", mem_en, 1'b1);
    check("stream first addr", mem_addr, 10'h000);
    step(); step();                                      // cycle 3
    check("stream first valid", instr_valid, 1'b1);
    check("stream first instr", instr, 32'h0000_0001);
    check("stream first pc", instr_pc, 10'h000);
    step(); step(); step(); step();                      // cycle 7
    check("stream halt instr", instr, 32'hFC00_0000);
    check("stream halt pc", instr_pc, 10'h004);
    step();                                              // cycle 8
    check("stream done", done, 1'b1);
    check("stream no word 5", instr_valid, 1'b0);

    // Backpressure: decode stalls five cycles; FIFO fills and issue stops.
    fill(0);
    mem[30] = 32'hFC00_1234;
    instr_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    instr_ready = 1'b0;
    repeat (5) step();
    check("bp valid held", instr_valid, 1'b1);
    check("bp mem_en low", mem_en, 1'b0);
    check("bp head pc", instr_pc, 10'h000);
    instr_ready = 1'b1;
    wait_done(100, "backpressure");

    // Redirect while the pc 2 read is in flight, coincident with a pop.
    fill(0);
    mem[10'h048] = 32'hFC00_0048;
    instr_ready = 1'b1;
    pulse_start();                                       // cycle 1
    step(); step(); step();                              // cycle 4
    redirect = 1'b1; redirect_pc = 10'h040;
    step();                                              // cycle 5
    redirect = 1'b0;
    check("redir flushed", instr_valid, 1'b0);
    step(); step();                                      // cycle 7
    check("redir target valid", instr_valid, 1'b1);
    check("redir target pc", instr_pc, 10'h040);
    wait_done(100, "redirect");

    // Redirect during DRAIN is ignored.
    fill(0);
    mem[1] = 32'hFC00_0001;
    instr_ready = 1'b0;
    pulse_start();                                       // cycle 1
    step(); step(); step();                              // cycle 4, draining
    redirect = 1'b1; redirect_pc = 10'h100;
    step();
    redirect = 1'b0;
    check("drain busy", busy, 1'b1);
    check("drain head pc", instr_pc, 10'h000);
    instr_ready = 1'b1;
    wait_done(20, "drain redirect");
    check("drain last pc", last_pop_pc, 10'h001);

    // End of memory: jump near the top, fetch through 0x3FF, no wrap.
    fill(0);
    instr_ready = 1'b1;
    pulse_start();
    step();
    redirect = 1'b1; redirect_pc = 10'h3FC;
    step();
    redirect = 1'b0;
    wait_done(40, "end of memory");
    check("eom last pc", last_pop_pc, 10'h3FF);

    // Reset mid-RUN with one word buffered.
    fill(0);
    mem[10] = 32'hFC00_000A;
    instr_ready = 1'b0;
    pulse_start();
    step(); step();
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 1'b0);
    check("midreset valid", instr_valid, 1'b0);
    check("midreset instr", instr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    instr_ready = 1'b1;
    pulse_start();
    check("restart mem_en", mem_en, 1'b1);
    check("restart addr", mem_addr, 10'h000);
    wait_done(100, "restart");

    // Randomized traffic.
    fill(3);
    for (int c = 0; c < 4000; c++) begin
      instr_ready = ($urandom_range(3) != 0);
      redirect    = ($urandom_range(15) == 0);
      redirect_pc = 10'($urandom);
      start       = ($urandom_range(7) == 0);
      rst_n       = ($urandom_range(499) != 0);
      step();
    end
    rst_n = 1'b1; start = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch for the NNSimulator core: drives a PC over a synchronous-read instruction memory, buffers returned 32-bit words in a small FIFO, and hands them to decode over a valid/ready handshake. Supports branch redirect with flush of in-flight and buffered words, and stops on a HALT opcode. Sits between the instruction memory and the decode stage. It replaces file-driven instruction capture with a synthesizable fetch path.

## Interface
- ADDR_W, 10, instruction memory word-address width
- DATA_W, 32, instruction width
- RESET_PC, 0, word address of the first fetch after `start`
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, ≥2)
- HALT_OPCODE, 6'h3F, value of instr[31:26] that ends the program
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins fetch from RESET_PC when in IDLE or DONE
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- redirect  in  1  branch taken; honoured only in RUN
- redirect_pc  in  ADDR_W  branch target
- mem_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en
- instr_valid  out  1  FIFO not empty
- instr_ready  in  1  decode accepts
- instr  out  DATA_W  FIFO head word
- instr_pc  out  ADDR_W  address of FIFO head word

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE; all outputs 0; PC=RESET_PC; FIFO empty; no in-flight.
- IDLE/DONE --start--> RUN; PC←RESET_PC; FIFO flushed (already empty).
- Issue (combinational): mem_en = RUN && !redirect && (count + inflight − pop) < FIFO_DEPTH, where pop = instr_valid && instr_ready. mem_addr = PC. On issue PC←PC+1, inflight←1, issued address saved for instr_pc.
- Response: cycle after issue, mem_rdata and its address pushed into FIFO unless killed.
- Redirect in RUN: PC←redirect_pc; FIFO flushed; in-flight response killed (not pushed); a pop in the same cycle completes first. No issue that cycle; first issue from redirect_pc next cycle.
- Halt: a pushed word with [31:26]==HALT_OPCODE is enqueued normally; RUN→DRAIN same edge; issue stops; the response issued alongside it (PC+1) is killed.
- End of memory: issue at address 2^ADDR_W−1 is last; RUN→DRAIN after its push (no wrap).
- DRAIN: redirect ignored; when FIFO empty → DONE. done stays high until start.
- start in RUN/DRAIN ignored.
- FIFO: push and pop in the same cycle with count==FIFO_DEPTH is legal (issue rule guarantees no overflow); pop on empty impossible (instr_valid=0).

## Timing
- start sampled at edge 0 → RUN cycle 1; mem_en=1, mem_addr=RESET_PC in cycle 1; push at edge 2; instr_valid=1 in cycle 3. Start-to-first-instruction latency 3 cycles.
- With instr_ready held high: one instruction per cycle sustained.
- instr_ready low: at most FIFO_DEPTH words buffered; mem_en drops once count+inflight reaches FIFO_DEPTH.
- Redirect at cycle t: instr_valid=0 in t+1; target word valid in t+3.
- DONE asserted the cycle after the halt word is popped.
- rst_n low at any time: immediate return to reset values; pending response discarded.

## Configuration
- FETCH_TRACE_EN defined: each FIFO push prints "fetch pc=%h instr=%h" via $display; redirect and halt also print one line. Simulation only.
- Undefined: no display statements; logic identical.

## Test plan
- Reset/idle: rst_n low mid-RUN with 1 word buffered → all outputs 0, state IDLE, next start fetches RESET_PC.
- Streaming: memory holds 0x00000001..0x00000004 then 0xFC000000, ready high → instr 1,2,3,4,0xFC000000 on consecutive cycles from cycle 3, instr_pc 0..4, done one cycle after last pop; word at address 5 never presented.
- Backpressure: ready low 5 cycles after first valid → count=2, mem_en low, no word lost or duplicated; release → resumes in order.
- Redirect: redirect=1, redirect_pc=0x040 while word at pc 2 in flight → pc 2 word discarded, next instr_pc=0x040 three cycles later.
- Redirect coincident with pop and with halt push in DRAIN → pop completes; redirect in DRAIN ignored, done still reached.
- End of memory (ADDR_W=3, no halt): fetch 0..7 then DONE, mem_addr never wraps to 0.
